// File: rtl/ifetch_stage.sv
// rtl/ifetch_stage.sv - instruction-fetch stage: imem handshake, IF/ID register, next-PC select
//
// Purpose
//   Sits directly after the PC register. Fetches the word at pc_i over a
//   req/ready instruction-memory handshake, loads the IF/ID pipeline register,
//   absorbs hazard stalls and branch flushes, and computes the next PC that is
//   fed back into the PC register every cycle.
//
// Ports
//   clk_i            in   1   clock, rising edge
//   rst_i            in   1   asynchronous active-low reset
//   start_i          in   1   synchronous restart (same strobe that zeroes the PC)
//   pc_i             in   32  current PC
//   stall_i          in   1   hold IF/ID, do not advance the PC
//   flush_i          in   1   branch taken in ID: squash fetch, redirect the PC
//   branch_target_i  in   32  redirect address, sampled while flush_i=1
//   imem_req_o       out  1   fetch request
//   imem_addr_o      out  32  word-aligned fetch address
//   imem_ready_i     in   1   read data valid this cycle
//   imem_rdata_i     in   32  instruction word
//   pc_next_o        out  32  next PC (combinational)
//   ifid_inst_o      out  32  IF/ID instruction
//   ifid_pc4_o       out  32  IF/ID PC+4
//   ifid_valid_o     out  1   IF/ID holds a real instruction
//   err_o            out  1   sticky imem timeout flag

module ifetch_stage #(
    parameter logic [31:0] NOP_INST = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] pc_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_next_o,
    output logic [31:0] ifid_inst_o,
    output logic [31:0] ifid_pc4_o,
    output logic        ifid_valid_o,
    output logic        err_o
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      ifid_inst_q, ifid_inst_d;
    logic [31:0]      ifid_pc4_q, ifid_pc4_d;
    logic             ifid_valid_q, ifid_valid_d;
    logic [31:0]      buf_q, buf_d;           // instruction captured while stalled
    logic             pend_q, pend_d;         // flush seen while waiting for ready
    logic [31:0]      pend_tgt_q, pend_tgt_d; // redirect target for the pending flush
    logic [CNT_W-1:0] cnt_q, cnt_d;           // wait cycles of the current request
    logic             err_q, err_d;

    logic [31:0] pc_plus4;

    // Wraps modulo 2^32 by construction.
    assign pc_plus4 = pc_i + 32'd4;

    // Request is a pure function of state, so an asynchronous reset drops it
    // immediately. The address follows pc_i, which the PC register holds
    // steady while we wait (pc_next_o = pc_i), keeping req/addr stable.
    assign imem_req_o  = (state_q == S_FETCH);
    assign imem_addr_o = {pc_i[31:2], 2'b00};

    always_comb begin
        state_d      = state_q;
        ifid_inst_d  = ifid_inst_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        buf_d        = buf_q;
        pend_d       = pend_q;
        pend_tgt_d   = pend_tgt_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        pc_next_o    = pc_i;

        // A bubble clears valid and the instruction; ifid_pc4 is left as is
        // because nothing downstream consumes it without valid.
        if (start_i) begin
            state_d      = S_IDLE;
            pc_next_o    = 32'd0;
            ifid_inst_d  = NOP_INST;
            ifid_valid_d = 1'b0;
            pend_d       = 1'b0;
            cnt_d        = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    pc_next_o    = 32'd0;
                    ifid_inst_d  = NOP_INST;
                    ifid_valid_d = 1'b0;
                    state_d      = S_FETCH;
                end

                S_FETCH: begin
                    if (!imem_ready_i) begin
                        // Waiting: PC holds, count toward the timeout.
                        pc_next_o = pc_i;
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        if (cnt_q == CNT_LAST) begin
                            err_d = 1'b1;
                        end
                        if (flush_i) begin
                            // The request cannot be withdrawn; remember where to
                            // go once the (now stale) response arrives.
                            pend_d       = 1'b1;
                            pend_tgt_d   = branch_target_i;
                            ifid_inst_d  = NOP_INST;
                            ifid_valid_d = 1'b0;
                        end else if (!stall_i) begin
                            ifid_inst_d  = NOP_INST;
                            ifid_valid_d = 1'b0;
                        end
                    end else begin
                        cnt_d = '0;
                        if (flush_i) begin
                            pc_next_o    = branch_target_i;
                            pend_d       = 1'b0;
                            ifid_inst_d  = NOP_INST;
                            ifid_valid_d = 1'b0;
                        end else if (pend_q) begin
                            pc_next_o    = pend_tgt_q;
                            pend_d       = 1'b0;
                            ifid_inst_d  = NOP_INST;
                            ifid_valid_d = 1'b0;
                        end else if (stall_i) begin
                            buf_d     = imem_rdata_i;
                            pc_next_o = pc_i;
                            state_d   = S_HOLD;
                        end else begin
                            ifid_inst_d  = imem_rdata_i;
                            ifid_pc4_d   = pc_plus4;
                            ifid_valid_d = 1'b1;
                            pc_next_o    = pc_plus4;
                        end
                    end
                end

                S_HOLD: begin
                    if (flush_i) begin
                        pc_next_o    = branch_target_i;
                        ifid_inst_d  = NOP_INST;
                        ifid_valid_d = 1'b0;
                        state_d      = S_FETCH;
                    end else if (!stall_i) begin
                        ifid_inst_d  = buf_q;
                        ifid_pc4_d   = pc_plus4;
                        ifid_valid_d = 1'b1;
                        pc_next_o    = pc_plus4;
                        state_d      = S_FETCH;
                    end else begin
                        pc_next_o = pc_i;
                    end
                end

                default: begin
                    state_d   = S_IDLE;
                    pc_next_o = 32'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            ifid_inst_q  <= NOP_INST;
            ifid_pc4_q   <= 32'd0;
            ifid_valid_q <= 1'b0;
            buf_q        <= 32'd0;
            pend_q       <= 1'b0;
            pend_tgt_q   <= 32'd0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ifid_inst_q  <= ifid_inst_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            buf_q        <= buf_d;
            pend_q       <= pend_d;
            pend_tgt_q   <= pend_tgt_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

    assign ifid_inst_o  = ifid_inst_q;
    assign ifid_pc4_o   = ifid_pc4_q;
    assign ifid_valid_o = ifid_valid_q;
    assign err_o        = err_q;

endmodule
